poll_scheduler: RTL and testbench

Frame-based sensor poll sequencer for the counter datapath. Each periodic tick from the interval pulse generator (60 ms) starts one polling frame. A frame walks the enabled sensor channels in ascending index order, issuing a one-cycle start to each and waiting for its done or a timeout. Frame completion, per-channel timeouts and dropped ticks (overruns) are reported to the counting logic.

---
 rtl/poll_scheduler.sv | 146 ++++++++++++++
 tb/tb_poll_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poll_scheduler.sv
// Frame-based sensor poll sequencer: each tick walks the enabled channels
// in ascending order, issuing a start and waiting for done or a timeout.
// Ports: clk, rst (async active-low), tick, ch_en, done, clr_flags ->
//   start (one-hot pulse), busy, active_ch, frame_done, timeout_flags,
//   overrun_cnt (saturating count of ticks dropped while busy).
module poll_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] done,
  input  logic              clr_flags,
  output logic [NUM_CH-1:0] start,
  output logic              busy,
  output logic [2:0]        active_ch,
  output logic              frame_done,
  output logic [NUM_CH-1:0] timeout_flags,
  output logic [7:0]        overrun_cnt
);

  // idx must be able to hold NUM_CH itself (the end-of-frame marker)
  localparam int IW = $clog2(NUM_CH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [IW-1:0] LAST = IW'(NUM_CH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_START,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [NUM_CH-1:0] en_q;
  logic [IW-1:0]     idx_q;
  logic [TW-1:0]     timer_q;
  logic [NUM_CH-1:0] start_q;
  logic              busy_q;
  logic [2:0]        act_q;
  logic              fdone_q;
  logic [NUM_CH-1:0] flags_q;
  logic [NUM_CH-1:0] flags_d;
  logic [7:0]        ovr_q;
  logic [7:0]        ovr_d;

  logic [NUM_CH-1:0] idx_oh;
  logic              en_sel;
  logic              done_sel;
  logic              to_hit;
  logic              ovr_hit;

  // One-hot view of idx; stays all-zero once idx reaches NUM_CH
  always_comb begin
    idx_oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == IW'(i)) idx_oh[i] = 1'b1;
    end
  end

  assign en_sel   = |(en_q & idx_oh);
  assign done_sel = |(done & idx_oh);
  assign to_hit   = (state_q == S_WAIT) && !done_sel
                    && (timer_q == TMAX);
  assign ovr_hit  = tick && (state_q != S_IDLE);

  // Clear is applied first so a same-cycle set/increment survives
  always_comb begin
    flags_d = clr_flags ? '0 : flags_q;
    if (to_hit) flags_d = flags_d | idx_oh;
    ovr_d = clr_flags ? 8'd0 : ovr_q;
    if (ovr_hit && (ovr_d != 8'hFF)) ovr_d = ovr_d + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      start_q <= '0;
      busy_q  <= 1'b0;
      act_q   <= '0;
      fdone_q <= 1'b0;
      flags_q <= '0;
      ovr_q   <= '0;
    end else begin
      flags_q <= flags_d;
      ovr_q   <= ovr_d;
      start_q <= '0;
      fdone_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (tick) begin
            en_q    <= ch_en;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (idx_q == LAST) begin
            fdone_q <= 1'b1;
            state_q <= S_DONE;
          end else if (en_sel) begin
            start_q <= idx_oh;
            act_q   <= 3'(idx_q);
            state_q <= S_START;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (done_sel || (timer_q == TMAX)) begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_SCAN;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start         = start_q;
  assign busy          = busy_q;
  assign active_ch     = act_q;
  assign frame_done    = fdone_q;
  assign timeout_flags = flags_q;
  assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_poll_scheduler.sv
// Scoreboard bench for poll_scheduler: expected start/frame_done events
// are queued at tick time and matched by a free-running monitor.
module tb_poll_scheduler;

  localparam int N  = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick = 1'b0;
  logic         clr_flags = 1'b0;
  logic [N-1:0] ch_en = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] start;
  logic         busy;
  logic [2:0]   active_ch;
  logic         frame_done;
  logic [N-1:0] timeout_flags;
  logic [7:0]   overrun_cnt;

  poll_scheduler #(
    .NUM_CH        (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .ch_en        (ch_en),
    .done         (done),
    .clr_flags    (clr_flags),
    .start        (start),
    .busy         (busy),
    .active_ch    (active_ch),
    .frame_done   (frame_done),
    .timeout_flags(timeout_flags),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; read only on falling edges
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit fd;
    int ch;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  dly[N];
  int  due[N];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cyc %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic void push(input bit fd, input int ch, input int at);
    ev_t e;
    e.fd = fd;
    e.ch = ch;
    e.at = at;
    exp_q.push_back(e);
  endfunction

  function automatic int ch_of(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_dly(input int a, input int b, input int c,
                         input int d);
    dly[0] = a;
    dly[1] = b;
    dly[2] = c;
    dly[3] = d;
  endtask

  // Called on a falling edge; tick is sampled at edge k.
  // ch_en is scrambled afterwards: it must not affect the running frame.
  task automatic issue(input logic [N-1:0] m, output int k);
    ch_en = m;
    tick  = 1'b1;
    k     = cyc + 1;
    @(negedge clk);
    tick  = 1'b0;
    ch_en = ~m;
  endtask

  // Monitor
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst && ((start != '0) || frame_done)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out start=%b fd=%b cyc %0d",
                   start, frame_done, cyc);
        end else begin
          e = exp_q.pop_front();
          if (frame_done) begin
            chk("fd_kind", 1, int'(e.fd));
            chk("fd_cycle", cyc, e.at);
          end else begin
            chk("start_kind", 0, int'(e.fd));
            chk("start_onehot", int'($onehot(start)), 1);
            chk("start_ch", ch_of(start), e.ch);
            chk("start_cycle", cyc, e.at);
            chk("active_ch", int'(active_ch), e.ch);
          end
        end
      end
    end
  end

  // Sensor responder: done[i] pulses dly[i] cycles after start[i]
  initial begin
    for (int i = 0; i < N; i++) due[i] = -1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (start[i] && dly[i] > 0) due[i] = cyc + dly[i];
        done[i] = (cyc == due[i]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int drops;
    set_dly(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_start", int'(start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_active", int'(active_ch), 0);
    chk("rst_fd", int'(frame_done), 0);
    chk("rst_flags", int'(timeout_flags), 0);
    chk("rst_ovr", int'(overrun_cnt), 0);
    rst = 1'b1;
    @(negedge clk);

    // Full frame
    set_dly(3, 3, 3, 3);
    issue(4'b1111, k);
    push(0, 0, k + 1);
    push(0, 1, k + 6);
    push(0, 2, k + 11);
    push(0, 3, k + 16);
    push(1, 0, k + 21);
    wait_until(k + 21);
    chk("busy_in_done", int'(busy), 1);
    wait_until(k + 22);
    chk("full_busy_low", int'(busy), 0);
    chk("full_flags", int'(timeout_flags), 0);
    chk("full_ovr", int'(overrun_cnt), 0);
    chk("full_q_empty", exp_q.size(), 0);

    // Sparse mask
    issue(4'b1010, k);
    push(0, 1, k + 2);
    push(0, 3, k + 8);
    push(1, 0, k + 13);
    wait_until(k + 14);
    chk("sparse_busy_low", int'(busy), 0);
    chk("sparse_q_empty", exp_q.size(), 0);

    // Timeout on ch2
    set_dly(3, 3, 0, 3);
    issue(4'b1111, k);
    push(0, 0, k + 1);
    push(0, 1, k + 6);
    push(0, 2, k + 11);
    push(0, 3, k + 29);
    push(1, 0, k + 34);
    wait_until(k + 35);
    chk("to_flags", int'(timeout_flags), 4);
    chk("to_busy_low", int'(busy), 0);

    set_dly(3, 3, 3, 3);
    issue(4'b1111, k);
    push(0, 0, k + 1);
    push(0, 1, k + 6);
    push(0, 2, k + 11);
    push(0, 3, k + 16);
    push(1, 0, k + 21);
    wait_until(k + 22);
    chk("to_flags_persist", int'(timeout_flags), 4);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("clr_flags", int'(timeout_flags), 0);

    // Done on the last timer cycle wins over timeout
    set_dly(0, 16, 3, 0);
    issue(4'b0110, k);
    push(0, 1, k + 2);
    push(0, 2, k + 20);
    push(1, 0, k + 26);
    wait_until(k + 27);
    chk("coinc_flags", int'(timeout_flags), 0);

    // Three ticks dropped mid-WAIT
    set_dly(10, 0, 0, 0);
    issue(4'b0001, k);
    push(0, 0, k + 1);
    push(1, 0, k + 16);
    foreach (dly[j]) begin
      if (j < 3) begin
        wait_until(k + 3 + 2 * j);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
      end
    end
    wait_until(k + 20);
    chk("ovr3_cnt", int'(overrun_cnt), 3);
    chk("ovr3_flags", int'(timeout_flags), 0);
    chk("ovr3_busy_low", int'(busy), 0);

    // 300 dropped ticks saturate the counter
    drops = 0;
    set_dly(0, 0, 0, 0);
    while (drops < 300) begin
      issue(4'b1111, k);
      push(0, 0, k + 1);
      push(0, 1, k + 19);
      push(0, 2, k + 37);
      push(0, 3, k + 55);
      push(1, 0, k + 73);
      for (int c = k; c <= k + 73; c++) begin
        wait_until(c);
        tick = (drops < 300);
        if (tick) drops++;
      end
      wait_until(k + 74);
      tick = 1'b0;
    end
    chk("sat_cnt", int'(overrun_cnt), 255);
    chk("sat_flags", int'(timeout_flags), 15);
    chk("sat_busy_low", int'(busy), 0);

    // clr_flags together with a dropped tick
    set_dly(5, 0, 0, 0);
    issue(4'b0001, k);
    push(0, 0, k + 1);
    push(1, 0, k + 11);
    wait_until(k + 3);
    tick = 1'b1;
    clr_flags = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    clr_flags = 1'b0;
    chk("clr_tick_cnt", int'(overrun_cnt), 1);
    chk("clr_tick_flags", int'(timeout_flags), 0);
    wait_until(k + 12);
    chk("clr_tick_cnt_end", int'(overrun_cnt), 1);

    // Async reset while start[1] is high
    set_dly(0, 0, 0, 0);
    issue(4'b1111, k);
    push(0, 0, k + 1);
    push(0, 1, k + 19);
    wait_until(k + 19);
    chk("pre_rst_flags", int'(timeout_flags), 1);
    chk("pre_rst_start", int'(start), 2);
    #1 rst = 1'b0;
    #1;
    chk("arst_start", int'(start), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_fd", int'(frame_done), 0);
    chk("arst_flags", int'(timeout_flags), 0);
    chk("arst_ovr", int'(overrun_cnt), 0);
    chk("arst_active", int'(active_ch), 0);
    repeat (2) @(negedge clk);
    chk("arst_q_empty", exp_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    set_dly(3, 3, 3, 3);
    issue(4'b1111, k);
    push(0, 0, k + 1);
    push(0, 1, k + 6);
    push(0, 2, k + 11);
    push(0, 3, k + 16);
    push(1, 0, k + 21);
    wait_until(k + 22);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_flags", int'(timeout_flags), 0);
    repeat (3) @(negedge clk);
    chk("final_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
